// File: rtl/spike_window_decoder.sv
// Per-class spike counting over a fixed window, followed by a sequential argmax.
// The winning class, its count and a tie flag are presented through a valid/ready handshake.
module spike_window_decoder #(
  parameter int unsigned NUM_CLASSES   = 4,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned WINDOW_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_CLASSES-1:0]         spikes_in,
  output logic                           busy,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [$clog2(NUM_CLASSES)-1:0] class_id,
  output logic [CNT_WIDTH-1:0]           class_count,
  output logic                           tie
);

  localparam int unsigned ID_W  = $clog2(NUM_CLASSES);
  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_CLASSES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COUNT, ARGMAX, HOLD} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt [NUM_CLASSES];
  logic [WIN_W-1:0]     win_cnt;
  logic [ID_W-1:0]      idx;
  logic [CNT_WIDTH-1:0] best, nxt_best, cur;
  logic [ID_W-1:0]      best_id, nxt_id;
  logic                 best_tie, nxt_tie;

  // Running argmax step for the class currently addressed by idx.
  always_comb begin
    nxt_best = best;
    nxt_id   = best_id;
    nxt_tie  = best_tie;
    cur      = cnt[idx];
    if (idx == '0) begin
      nxt_best = cur;
      nxt_id   = '0;
      nxt_tie  = 1'b0;
    end else if (cur > best) begin
      nxt_best = cur;
      nxt_id   = idx;
      nxt_tie  = 1'b0;
    end else if (cur == best) begin
      nxt_tie  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      win_cnt      <= '0;
      idx          <= '0;
      best         <= '0;
      best_id      <= '0;
      best_tie     <= 1'b0;
      class_id     <= '0;
      class_count  <= '0;
      tie          <= 1'b0;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
    end else if (abort) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            win_cnt <= '0;
            state   <= COUNT;
            busy    <= 1'b1;
          end
        end
        COUNT: begin
          for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            if (spikes_in[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
          end
          if (win_cnt == WIN_LAST) begin
            idx   <= '0;
            state <= ARGMAX;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end
        ARGMAX: begin
          best     <= nxt_best;
          best_id  <= nxt_id;
          best_tie <= nxt_tie;
          if (idx == LAST_ID) begin
            class_id     <= nxt_id;
            class_count  <= nxt_best;
            tie          <= nxt_tie;
            result_valid <= 1'b1;
            state        <= HOLD;
          end else begin
            idx <= idx + ID_W'(1);
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench for spike_window_decoder: a time-based window/argmax model checked every cycle,
// plus literal expectations for the example windows, plus a saturating narrow-counter instance.
module tb_spike_window_decoder;

  localparam int NC = 4;
  localparam int W  = 16;
  localparam int W2 = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, result_ready = 1'b0;
  logic [NC-1:0] spikes_in = '0;
  logic          busy, result_valid, tie;
  logic [1:0]    class_id;
  logic [7:0]    class_count;

  logic          start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b0;
  logic [NC-1:0] spikes2 = '0;
  logic          busy2, valid2, tie2;
  logic [1:0]    id2;
  logic [3:0]    count2;

  int checks = 0;
  int failures = 0;

  spike_window_decoder #(.NUM_CLASSES(NC), .CNT_WIDTH(8), .WINDOW_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .spikes_in(spikes_in),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .class_id(class_id), .class_count(class_count), .tie(tie)
  );

  spike_window_decoder #(.NUM_CLASSES(NC), .CNT_WIDTH(4), .WINDOW_CYCLES(W2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .spikes_in(spikes2),
    .busy(busy2), .result_valid(valid2), .result_ready(ready2),
    .class_id(id2), .class_count(count2), .tie(tie2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a window opened by an accepted start at edge t0 counts edges t0+1..t0+W,
  // and its result appears after edge t0+W+NC.
  int  cyc = 0, m_t0 = 0;
  bit  m_active = 0, m_hold = 0, m_tie = 0;
  int  m_id = 0, m_cnt = 0;
  int  sums [NC];

  function automatic void finalize();
    int mx, n_at_max;
    mx = -1; n_at_max = 0;
    for (int i = 0; i < NC; i++) begin
      int s;
      s = (sums[i] > 255) ? 255 : sums[i];
      if (s > mx) begin mx = s; m_id = i; end
    end
    for (int i = 0; i < NC; i++) if (((sums[i] > 255) ? 255 : sums[i]) == mx) n_at_max++;
    m_cnt = mx;
    m_tie = (n_at_max > 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_hold = 0; m_id = 0; m_cnt = 0; m_tie = 0;
    end else begin
      cyc++;
      if (abort) begin
        m_active = 0; m_hold = 0;
      end else if (m_hold) begin
        if (result_ready) m_hold = 0;
      end else if (m_active) begin
        int k;
        k = cyc - m_t0;
        if (k <= W) for (int i = 0; i < NC; i++) sums[i] += int'(spikes_in[i]);
        if (k == W + NC) begin
          finalize();
          m_active = 0; m_hold = 1;
        end
      end else if (start) begin
        m_active = 1; m_t0 = cyc;
        for (int i = 0; i < NC; i++) sums[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_active || m_hold);
    chk("result_valid", result_valid, m_hold);
    chk("class_id", class_id, m_id);
    chk("class_count", class_count, m_cnt);
    chk("tie", tie, m_tie);
  end

  task automatic step(input logic s, input logic a, input logic [NC-1:0] sp, input logic r);
    @(negedge clk);
    start = s; abort = a; spikes_in = sp; result_ready = r;
  endtask

  function automatic logic [NC-1:0] pat(input int tid, input int k);
    logic [NC-1:0] p;
    p = '0;
    case (tid)
      1: begin p[2] = 1'b1; p[1] = (k % 2 == 0); end
      2: begin p[1] = (k < 5); p[3] = (k >= 10 && k < 15); end
      4: p[3] = (k < 4);
      5: p[2] = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Spikes on every line during the start cycle and after the window must not be counted.
  task automatic run_window(input int tid);
    int n;
    step(1'b1, 1'b0, '1, 1'b0);
    for (int k = 0; k < W; k++) step((tid == 2 && k == 6), 1'b0, pat(tid, k), 1'b0);
    n = 0;
    do begin
      step(1'b0, 1'b0, '1, 1'b0);
      n++;
    end while (!result_valid && n < 30);
    chk("result_latency", 16 + n, W + NC + 1);
  endtask

  task automatic handshake(input logic with_start);
    step(with_start, 1'b0, '1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("post_hs_valid", result_valid, 0);
    chk("post_hs_busy", busy, 0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("post_hs_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", class_id, 0);
    chk("rst_count", class_count, 0);
    chk("rst_tie", tie, 0);
    @(negedge clk); rst_n = 1'b1;

    // class 2 every cycle, class 1 every other cycle
    run_window(1);
    chk("t1_id", class_id, 2);
    chk("t1_count", class_count, 16);
    chk("t1_tie", tie, 0);
    for (int i = 0; i < 10; i++) begin
      step((i == 3), 1'b0, '1, 1'b0);
      chk("hold_valid", result_valid, 1);
      chk("hold_count", class_count, 16);
      chk("hold_id", class_id, 2);
    end
    handshake(1'b0);

    // classes 1 and 3 spike 5 times each; start pulsed mid-count; start during handshake
    run_window(2);
    chk("t2_id", class_id, 1);
    chk("t2_count", class_count, 5);
    chk("t2_tie", tie, 1);
    handshake(1'b1);

    run_window(3);
    chk("t3_id", class_id, 0);
    chk("t3_count", class_count, 0);
    chk("t3_tie", tie, 1);
    handshake(1'b0);

    // abort at window cycle 7 with class 0 spiking, then a clean window
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 4'b0001, 1'b0);
    step(1'b1, 1'b1, 4'b0001, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_keeps_tie", tie, 1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'b0001, 1'b0);
    chk("abort_stays_idle", busy, 0);
    run_window(4);
    chk("t4_id", class_id, 3);
    chk("t4_count", class_count, 4);
    chk("t4_tie", tie, 0);
    handshake(1'b0);

    // reset while holding a result
    run_window(5);
    chk("t5_count", class_count, 16);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstH_valid", result_valid, 0);
    chk("rstH_busy", busy, 0);
    chk("rstH_count", class_count, 0);
    chk("rstH_id", class_id, 0);
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);

    // narrow counter saturates at 15 over a 32-cycle window
    @(negedge clk); start2 = 1'b1; spikes2 = 4'b0001;
    @(negedge clk); start2 = 1'b0;
    n = 0;
    while (!valid2 && n < 60) begin @(negedge clk); n++; end
    chk("sat_latency", n + 1, W2 + NC + 1);
    chk("sat_valid", valid2, 1);
    chk("sat_count", count2, 15);
    chk("sat_id", id2, 0);
    chk("sat_tie", tie2, 0);
    spikes2 = '0; ready2 = 1'b1;
    @(negedge clk); ready2 = 1'b0;
    chk("sat_done", valid2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
